// File: rtl/circ_pkg.sv
// Shared constants and types for the circular interpolator step stage.
package circ_pkg;

  localparam int DEF_COORD_W = 16;
  localparam int DEF_F_W     = 2 * DEF_COORD_W + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {
    MX_P,
    MX_N,
    MY_P,
    MY_N
  } move_t;

endpackage

// File: rtl/circ_quad_decide.sv
// Quadrant and deviation-sign lookup selecting the next single-axis move.
module circ_quad_decide
  import circ_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               f_neg,
  input  logic               cw,
  output move_t              move
);

  logic x_neg, x_pos, y_neg, y_pos;

  assign x_neg = x[COORD_W-1];
  assign y_neg = y[COORD_W-1];
  assign x_pos = !x_neg && (x != '0);
  assign y_pos = !y_neg && (y != '0);

  // Origin matches no quadrant; the caller never steps from there.
  always_comb begin
    move = MX_P;
    if (!cw) begin
      if (x_pos && !y_neg)       move = f_neg ? MY_P : MX_N;
      else if (!x_pos && y_pos)  move = f_neg ? MX_N : MY_N;
      else if (x_neg && !y_pos)  move = f_neg ? MY_N : MX_P;
      else if (!x_neg && y_neg)  move = f_neg ? MX_P : MY_P;
    end else begin
      if (!x_neg && y_pos)       move = f_neg ? MX_P : MY_N;
      else if (x_neg && !y_neg)  move = f_neg ? MY_P : MX_P;
      else if (!x_pos && y_neg)  move = f_neg ? MX_N : MY_P;
      else if (x_pos && !y_pos)  move = f_neg ? MY_N : MX_N;
    end
  end

endmodule

// File: rtl/circ_interp_step.sv
// Point-by-point comparison circular interpolator: one X or Y step per pulse_clk rising edge.
module circ_interp_step
  import circ_pkg::*;
#(
  parameter int          COORD_W   = DEF_COORD_W,
  parameter int          F_W       = 2 * COORD_W + 2,
  parameter int unsigned MAX_STEPS = 1048575,
  parameter int          CNT_W     = 20
) (
  input  logic               sys_clk,
  input  logic               sys_rst_h,
  input  logic               pulse_clk,
  input  logic               cmd_validH,
  output logic               cmd_readyH,
  input  logic               cmd_cw,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic [COORD_W-1:0] end_x,
  input  logic [COORD_W-1:0] end_y,
  input  logic               abortH,
  output logic               step_x,
  output logic               step_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               busyH,
  output logic               doneH,
  output logic               errH
);

  logic [1:0]              state;
  logic                    pulse_d;
  logic                    tick;
  logic                    cw_q;
  logic [COORD_W-1:0]      ex_q, ey_q;
  logic [COORD_W-1:0]      x_q, y_q;
  logic signed [F_W-1:0]   f_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [F_W-1:0]   xe, ye, f_delta;
  logic                    at_end;
  logic                    origin_start;
  move_t                   move;

  localparam logic signed [F_W-1:0] F_ONE = {{(F_W-1){1'b0}}, 1'b1};

  assign tick         = pulse_clk && !pulse_d;
  assign cmd_readyH   = (state == ST_IDLE);
  assign cur_x        = x_q;
  assign cur_y        = y_q;
  assign at_end       = (x_q == ex_q) && (y_q == ey_q);
  assign origin_start = (start_x == '0) && (start_y == '0);
  assign xe           = {{(F_W-COORD_W){x_q[COORD_W-1]}}, x_q};
  assign ye           = {{(F_W-COORD_W){y_q[COORD_W-1]}}, y_q};

  circ_quad_decide #(
    .COORD_W(COORD_W)
  ) u_decide (
    .x    (x_q),
    .y    (y_q),
    .f_neg(f_q[F_W-1]),
    .cw   (cw_q),
    .move (move)
  );

  always_comb begin
    f_delta = F_ONE;
    case (move)
      MX_P:    f_delta = xe + xe + F_ONE;
      MX_N:    f_delta = F_ONE - xe - xe;
      MY_P:    f_delta = ye + ye + F_ONE;
      MY_N:    f_delta = F_ONE - ye - ye;
      default: f_delta = F_ONE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_h) begin
      state   <= ST_IDLE;
      pulse_d <= 1'b0;
      cw_q    <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      step_x  <= 1'b0;
      step_y  <= 1'b0;
      dir_x   <= 1'b0;
      dir_y   <= 1'b0;
      busyH   <= 1'b0;
      doneH   <= 1'b0;
      errH    <= 1'b0;
    end else begin
      pulse_d <= pulse_clk;
      step_x  <= 1'b0;
      step_y  <= 1'b0;
      doneH   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_validH) begin
            cw_q  <= cmd_cw;
            ex_q  <= end_x;
            ey_q  <= end_y;
            x_q   <= start_x;
            y_q   <= start_y;
            f_q   <= '0;
            cnt_q <= '0;
            errH  <= 1'b0;
            // A zero-radius arc completes at once without entering RUN.
            if (origin_start) begin
              doneH <= 1'b1;
            end else begin
              busyH <= 1'b1;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abortH) begin
            busyH <= 1'b0;
            state <= ST_IDLE;
          end else if (tick) begin
            case (move)
              MX_P: begin step_x <= 1'b1; dir_x <= 1'b1; x_q <= x_q + COORD_W'(1); end
              MX_N: begin step_x <= 1'b1; dir_x <= 1'b0; x_q <= x_q - COORD_W'(1); end
              MY_P: begin step_y <= 1'b1; dir_y <= 1'b1; y_q <= y_q + COORD_W'(1); end
              MY_N: begin step_y <= 1'b1; dir_y <= 1'b0; y_q <= y_q - COORD_W'(1); end
              default: ;
            endcase
            f_q   <= f_q + f_delta;
            cnt_q <= cnt_q + CNT_W'(1);
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (abortH) begin
            busyH <= 1'b0;
            state <= ST_IDLE;
          end else if (at_end && (cnt_q != '0)) begin
            doneH <= 1'b1;
            busyH <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt_q == CNT_W'(MAX_STEPS)) begin
            errH  <= 1'b1;
            busyH <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circ_interp_step.sv
// Directed bench for circ_interp_step: arcs, handshake, abort, step limit and reset.
module tb_circ_interp_step;

  logic        sys_clk;
  logic        sys_rst_h;
  logic        pulse_clk;
  logic        cmd_validH;
  logic        cmd_readyH;
  logic        cmd_cw;
  logic [15:0] start_x, start_y, end_x, end_y;
  logic        abortH;
  logic        step_x, step_y, dir_x, dir_y;
  logic [15:0] cur_x, cur_y;
  logic        busyH, doneH, errH;

  int n_checks = 0;
  int n_fail   = 0;

  int   sx_cnt = 0, sx_neg = 0, sy_cnt = 0, sy_pos = 0;
  int   done_cnt = 0, both_cnt = 0, lat_err = 0;
  logic pulse_prev = 1'b0;
  logic tick_prev  = 1'b0;

  circ_interp_step #(
    .COORD_W  (16),
    .F_W      (34),
    .MAX_STEPS(64),
    .CNT_W    (20)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_h (sys_rst_h),
    .pulse_clk (pulse_clk),
    .cmd_validH(cmd_validH),
    .cmd_readyH(cmd_readyH),
    .cmd_cw    (cmd_cw),
    .start_x   (start_x),
    .start_y   (start_y),
    .end_x     (end_x),
    .end_y     (end_y),
    .abortH    (abortH),
    .step_x    (step_x),
    .step_y    (step_y),
    .dir_x     (dir_x),
    .dir_y     (dir_y),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .busyH     (busyH),
    .doneH     (doneH),
    .errH      (errH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // A strobe is legal only if the previous sample saw a pulse_clk rising edge.
  always @(negedge sys_clk) begin
    if (step_x && step_y) both_cnt++;
    if ((step_x || step_y) && !tick_prev) lat_err++;
    if (step_x) begin sx_cnt++; if (!dir_x) sx_neg++; end
    if (step_y) begin sy_cnt++; if (dir_y) sy_pos++; end
    if (doneH) done_cnt++;
    tick_prev  = pulse_clk && !pulse_prev;
    pulse_prev = pulse_clk;
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic one_pulse();
    pulse_clk = 1'b1;
    cyc(4);
    pulse_clk = 1'b0;
    cyc(4);
  endtask

  task automatic send_cmd(input logic cw, input int sx, input int sy, input int ex, input int ey);
    cmd_cw     = cw;
    start_x    = 16'(sx);
    start_y    = 16'(sy);
    end_x      = 16'(ex);
    end_y      = 16'(ey);
    cmd_validH = 1'b1;
    cyc(1);
    cmd_validH = 1'b0;
  endtask

  task automatic run_arc(input int max_pulses);
    for (int i = 0; i < max_pulses && busyH; i++) one_pulse();
  endtask

  initial begin
    int b_x, b_y, b_xn, b_yp, b_done, b_both, b_lat;
    sys_rst_h  = 1'b1;
    pulse_clk  = 1'b0;
    cmd_validH = 1'b0;
    cmd_cw     = 1'b0;
    start_x    = '0;
    start_y    = '0;
    end_x      = '0;
    end_y      = '0;
    abortH     = 1'b0;
    cyc(3);
    check_val("rst_ready", cmd_readyH, 1);
    check_val("rst_busy", busyH, 0);
    check_val("rst_done", doneH, 0);
    check_val("rst_err", errH, 0);
    check_val("rst_steps", {step_x, step_y, dir_x, dir_y}, 0);
    check_val("rst_cur", {cur_x, cur_y}, 0);
    sys_rst_h = 1'b0;
    cyc(2);

    // CCW quarter arc (5,0) -> (0,5)
    b_x = sx_cnt; b_y = sy_cnt; b_xn = sx_neg; b_yp = sy_pos;
    b_done = done_cnt; b_lat = lat_err;
    send_cmd(1'b0, 5, 0, 0, 5);
    check_val("q_busy", busyH, 1);
    check_val("q_ready", cmd_readyH, 0);
    run_arc(40);
    check_val("q_x_steps", sx_cnt - b_x, 5);
    check_val("q_x_dir_neg", sx_neg - b_xn, 5);
    check_val("q_y_steps", sy_cnt - b_y, 5);
    check_val("q_y_dir_pos", sy_pos - b_yp, 5);
    check_val("q_done", done_cnt - b_done, 1);
    check_val("q_latency", lat_err - b_lat, 0);
    check_val("q_cur_x", $signed(cur_x), 0);
    check_val("q_cur_y", $signed(cur_y), 5);
    check_val("q_dir_held", {dir_x, dir_y}, 1);
    check_val("q_busy_end", busyH, 0);

    // CW full circle from (5,0), with a stray command while busy
    b_x = sx_cnt; b_y = sy_cnt; b_done = done_cnt; b_both = both_cnt; b_lat = lat_err;
    send_cmd(1'b1, 5, 0, 5, 0);
    for (int i = 0; i < 5; i++) one_pulse();
    cmd_cw = 1'b0; start_x = -16'sd3; start_y = 16'd2; end_x = 16'd1; end_y = 16'd1;
    cmd_validH = 1'b1;
    check_val("hs_ready_busy", cmd_readyH, 0);
    cyc(1);
    cmd_validH = 1'b0;
    check_val("hs_still_busy", busyH, 1);
    run_arc(60);
    check_val("fc_strobes", (sx_cnt - b_x) + (sy_cnt - b_y), 40);
    check_val("fc_both", both_cnt - b_both, 0);
    check_val("fc_latency", lat_err - b_lat, 0);
    check_val("fc_cur_x", $signed(cur_x), 5);
    check_val("fc_cur_y", $signed(cur_y), 0);
    check_val("fc_f", dut.f_q, 0);
    check_val("fc_done", done_cnt - b_done, 1);
    check_val("fc_ready", cmd_readyH, 1);

    // Abort coincident with the 4th tick of a CCW quarter arc
    b_x = sx_cnt; b_y = sy_cnt; b_done = done_cnt;
    send_cmd(1'b0, 5, 0, 0, 5);
    for (int i = 0; i < 3; i++) one_pulse();
    pulse_clk = 1'b1;
    abortH    = 1'b1;
    cyc(1);
    abortH = 1'b0;
    check_val("ab_busy", busyH, 0);
    check_val("ab_ready", cmd_readyH, 1);
    cyc(3);
    pulse_clk = 1'b0;
    cyc(4);
    check_val("ab_strobes", (sx_cnt - b_x) + (sy_cnt - b_y), 3);
    check_val("ab_done", done_cnt - b_done, 0);
    check_val("ab_cur_x", $signed(cur_x), 4);
    check_val("ab_cur_y", $signed(cur_y), 2);

    // Unreachable end point: (3,3) lies on the radius-5 path, (4,4) does not
    b_x = sx_cnt; b_y = sy_cnt; b_done = done_cnt;
    send_cmd(1'b0, 5, 0, 4, 4);
    run_arc(80);
    check_val("er_err", errH, 1);
    check_val("er_busy", busyH, 0);
    check_val("er_strobes", (sx_cnt - b_x) + (sy_cnt - b_y), 64);
    check_val("er_done", done_cnt - b_done, 0);
    send_cmd(1'b0, 0, 0, 1, 1);
    check_val("er_cleared", errH, 0);
    check_val("org_done", doneH, 1);
    check_val("org_busy", busyH, 0);
    cyc(1);
    check_val("org_done_pulse", doneH, 0);

    // Reset in the middle of an arc
    send_cmd(1'b0, 5, 0, 0, 5);
    one_pulse();
    one_pulse();
    pulse_clk = 1'b1;
    cyc(1);
    sys_rst_h = 1'b1;
    cyc(1);
    check_val("mr_ready", cmd_readyH, 1);
    check_val("mr_busy", busyH, 0);
    check_val("mr_flags", {doneH, errH}, 0);
    check_val("mr_steps", {step_x, step_y, dir_x, dir_y}, 0);
    check_val("mr_cur", {cur_x, cur_y}, 0);
    sys_rst_h = 1'b0;
    pulse_clk = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
